// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
// Shared definitions for the alu_issue block: data width, register-select
// width, operation encodings, FSM state encodings and the helpers that move
// between the external [0:7] buses (bit 0 = LSB) and internal [7:0] words.
// ---------------------------------------------------------------------------
package alu_issue_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LDI = 2'b10,
    OP_CMP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // External buses are declared [0:7] but bit 0 carries the LSB, so a plain
  // vector assignment would reverse the byte. Copy bit-by-bit by index.
  function automatic logic [DATA_W-1:0] bus_to_word(input logic [0:DATA_W-1] bus);
    logic [DATA_W-1:0] word;
    for (int i = 0; i < DATA_W; i++) begin
      word[i] = bus[i];
    end
    return word;
  endfunction

  function automatic logic [0:DATA_W-1] word_to_bus(input logic [DATA_W-1:0] word);
    logic [0:DATA_W-1] bus;
    for (int i = 0; i < DATA_W; i++) begin
      bus[i] = word[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/alu_issue_alu.sv
// ---------------------------------------------------------------------------
// alu_issue_alu
// Purely combinational 8-bit adder/subtractor.
//   a, b      : operands
//   subtract  : 0 -> r = a + b, 1 -> r = a - b (two's complement a + ~b + 1)
//   r         : result, modulo 256
//   carry     : carry-out; when subtracting, 1 means no borrow (a >= b)
// ---------------------------------------------------------------------------
module alu_issue_alu
  import alu_issue_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              subtract,
  output logic [DATA_W-1:0] r,
  output logic              carry
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  // Subtraction reuses the adder by inverting b and injecting a carry-in of
  // one; the carry-out then naturally reads as "no borrow".
  always_comb begin
    b_eff = subtract ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, subtract};
  end

  assign r     = sum[DATA_W-1:0];
  assign carry = sum[DATA_W];

endmodule

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Small issue/execute/writeback engine around a 4 x 8-bit register file.
// One operation completes every three cycles: accept (IDLE) -> EXEC -> WB.
//
// Ports
//   clk                      : single clock, rising edge
//   reset                    : synchronous, active-high
//   req_valid / req_ready    : request handshake, accepted when both are 1
//   req_op                   : 00 ADD, 01 SUB, 10 LDI, 11 CMP
//   req_dst/req_srca/req_srcb: register indices
//   req_imm [0:7]            : LDI immediate (bit 0 = LSB)
//   done                     : one-cycle completion pulse (during WB)
//   done_data [0:7]          : result, valid while done is high
//   flag_c/z/n/v             : registered status flags
//   rd_sel / rd_data [0:7]   : combinational observation read of the regfile
// ---------------------------------------------------------------------------
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int NREG = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SEL_W-1:0] req_dst,
  input  logic [SEL_W-1:0] req_srca,
  input  logic [SEL_W-1:0] req_srcb,
  input  logic [0:7]       req_imm,
  output logic             done,
  output logic [0:7]       done_data,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [0:7]       rd_data
);

  state_t            state;
  op_t               op_q;
  logic [SEL_W-1:0]  dst_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic              done_q;
  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] alu_r;
  logic              alu_carry;
  logic              alu_subtract;
  logic              accept;
  logic              v_calc;
  op_t               req_op_e;

  assign req_op_e = op_t'(req_op);

  // Ready is a pure function of the FSM state, forced low while reset is
  // held so nothing can be accepted on the reset edge.
  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // CMP is a subtract whose result is thrown away, so both share the ALU's
  // subtract path.
  assign alu_subtract = (op_q == OP_SUB) || (op_q == OP_CMP);

  alu_issue_alu u_alu (
    .a        (opa_q),
    .b        (opb_q),
    .subtract (alu_subtract),
    .r        (alu_r),
    .carry    (alu_carry)
  );

  // Signed overflow is judged from the latched operand signs and the
  // registered result sign. For subtraction the operand signs must differ
  // for overflow to be possible; for addition they must match.
  always_comb begin
    v_calc = 1'b0;
    case (op_q)
      OP_ADD:         v_calc = (opa_q[7] == opb_q[7]) && (result_q[7] != opa_q[7]);
      OP_SUB, OP_CMP: v_calc = (opa_q[7] != opb_q[7]) && (result_q[7] != opa_q[7]);
      default:        v_calc = 1'b0;
    endcase
  end

  // The done pulse and its data are masked by reset so that a reset landing
  // in WB aborts the operation without any visible completion.
  assign done      = done_q && !reset;
  assign done_data = (done_q && !reset) ? word_to_bus(result_q) : '0;
  assign rd_data   = word_to_bus(regs[rd_sel]);

  // Single FSM process. Operands are captured at accept time so any aliasing
  // of srca/srcb/dst is harmless. EXEC registers the ALU output, WB commits
  // the register write (skipped for CMP) and the flags. Reset has priority
  // over everything, including a write that would otherwise happen at the
  // end of WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      dst_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= req_op_e;
            dst_q <= req_dst;
            opa_q <= regs[req_srca];
            opb_q <= (req_op_e == OP_LDI) ? bus_to_word(req_imm) : regs[req_srcb];
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          result_q <= (op_q == OP_LDI) ? opb_q : alu_r;
          carry_q  <= alu_carry;
          done_q   <= 1'b1;
          state    <= ST_WB;
        end

        ST_WB: begin
          done_q <= 1'b0;
          if (op_q != OP_CMP) begin
            regs[dst_q] <= result_q;
          end
          flag_z <= (result_q == '0);
          flag_n <= result_q[7];
          if (op_q != OP_LDI) begin
            flag_c <= carry_q;
            flag_v <= v_calc;
          end
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
// Self-checking bench for alu_issue: directed scenarios followed by random
// operations, all compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [1:0] req_dst;
  logic [1:0] req_srca;
  logic [1:0] req_srcb;
  logic [0:7] req_imm;
  logic       done;
  logic [0:7] done_data;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;
  logic [1:0] rd_sel;
  logic [0:7] rd_data;

  int vec_count   = 0;
  int miscompares = 0;

  // Reference state: register contents and flags as plain integers.
  int model_regs [4];
  int model_c, model_z, model_n, model_v;

  always #5 clk = ~clk;

  alu_issue #(.NREG(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_dst   (req_dst),
    .req_srca  (req_srca),
    .req_srcb  (req_srcb),
    .req_imm   (req_imm),
    .done      (done),
    .done_data (done_data),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data)
  );

  // Buses carry the LSB in bit 0.
  function automatic logic [0:7] to_bus(input int value);
    logic [0:7] b;
    for (int i = 0; i < 8; i++) b[i] = value[i];
    return b;
  endfunction

  function automatic int from_bus(input logic [0:7] b);
    int v = 0;
    for (int i = 0; i < 8; i++) if (b[i] === 1'b1) v += (1 << i);
    return v;
  endfunction

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: compute the result and new flags from the rules,
  // returning the expected done_data.
  task automatic modelOp(input int op, input int dst, input int srca, input int srcb,
                         input int imm, output int res);
    int a, b, full, sdiff;
    a = model_regs[srca];
    b = (op == 2) ? imm : model_regs[srcb];
    res = 0;
    case (op)
      0: begin
        full    = a + b;
        res     = full % 256;
        model_c = (full > 255) ? 1 : 0;
        sdiff   = to_signed8(a) + to_signed8(b);
        model_v = (sdiff > 127 || sdiff < -128) ? 1 : 0;
      end
      1, 3: begin
        res     = (a - b + 256) % 256;
        model_c = (a >= b) ? 1 : 0;
        sdiff   = to_signed8(a) - to_signed8(b);
        model_v = (sdiff > 127 || sdiff < -128) ? 1 : 0;
      end
      default: res = b;
    endcase
    model_z = (res == 0) ? 1 : 0;
    model_n = (res >= 128) ? 1 : 0;
    if (op != 3) model_regs[dst] = res;
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      checkOutput($sformatf("%s_reg%0d", tag, i), from_bus(rd_data), model_regs[i]);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_c"}, int'(flag_c), model_c);
    checkOutput({tag, "_z"}, int'(flag_z), model_z);
    checkOutput({tag, "_n"}, int'(flag_n), model_n);
    checkOutput({tag, "_v"}, int'(flag_v), model_v);
  endtask

  // Issue one operation and follow it to completion. Called at posedge+1.
  task automatic applyStimulus(input string tag, input int op, input int dst,
                               input int srca, input int srcb, input int imm);
    int waited = 0;
    int cycles;
    int expected;
    while (req_ready !== 1'b1 && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({tag, "_ready"}, int'(req_ready), 1);
    if (req_ready !== 1'b1) return;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_dst   = 2'(dst);
    req_srca  = 2'(srca);
    req_srcb  = 2'(srcb);
    req_imm   = to_bus(imm);
    @(posedge clk); #1;
    // Request fields are don't-care once accepted.
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_dst   = 2'($urandom_range(0, 3));
    req_srca  = 2'($urandom_range(0, 3));
    req_srcb  = 2'($urandom_range(0, 3));
    req_imm   = to_bus(int'($urandom_range(0, 255)));
    modelOp(op, dst, srca, srcb, imm, expected);
    cycles = 1;
    while (done !== 1'b1 && cycles < 6) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, 2);
    checkOutput({tag, "_data"}, from_bus(done_data), expected);
    @(posedge clk); #1;
    checkOutput({tag, "_pulse_end"}, int'(done), 0);
    checkFlags(tag);
    checkRegs(tag);
  endtask

  initial begin
    int op, dst, sa, sb, imm;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_dst   = 2'b00;
    req_srca  = 2'b00;
    req_srcb  = 2'b00;
    req_imm   = '0;
    rd_sel    = 2'b00;
    for (int i = 0; i < 4; i++) model_regs[i] = 0;
    model_c = 0; model_z = 0; model_n = 0; model_v = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("ready_in_reset", int'(req_ready), 0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", int'(req_ready), 1);
    checkOutput("done_after_reset", int'(done), 0);
    checkFlags("reset_flags");
    checkRegs("reset");

    // Signed overflow into the sign bit.
    applyStimulus("ldi_r1", 2, 1, 0, 0, 8'h7F);
    applyStimulus("ldi_r2", 2, 2, 0, 0, 8'h01);
    applyStimulus("add_ovf", 0, 3, 1, 2, 0);

    // Borrow with a negative result.
    applyStimulus("ldi_r0", 2, 0, 0, 0, 8'h05);
    applyStimulus("ldi_r1b", 2, 1, 0, 0, 8'h07);
    applyStimulus("sub_borrow", 1, 2, 0, 1, 0);

    // Compare a register with itself: equal, no write.
    applyStimulus("cmp_self", 3, 1, 1, 1, 0);

    // Unsigned wrap to zero.
    applyStimulus("ldi_ff", 2, 0, 0, 0, 8'hFF);
    applyStimulus("ldi_01", 2, 1, 0, 0, 8'h01);
    applyStimulus("add_wrap", 0, 2, 0, 1, 0);

    // Reset landing in WB of LDI r3,0xAA aborts it.
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_dst   = 2'd3;
    req_srca  = 2'd0;
    req_srcb  = 2'd0;
    req_imm   = to_bus(8'hAA);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_done_wb", int'(done), 0);
    checkOutput("abort_ready_in_reset", int'(req_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = 0;
    model_c = 0; model_z = 0; model_n = 0; model_v = 0;
    #1;
    checkOutput("abort_done_after", int'(done), 0);
    checkOutput("abort_ready_after", int'(req_ready), 1);
    checkFlags("abort_flags");
    checkRegs("abort");
    @(posedge clk); #1;
    checkOutput("abort_no_late_done", int'(done), 0);

    // Random phase: seed every register, then random operations.
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("seed%0d", i), 2, i, 0, 0, int'($urandom_range(0, 255)));
    end
    for (int k = 0; k < 40; k++) begin
      op  = int'($urandom_range(0, 3));
      dst = int'($urandom_range(0, 3));
      sa  = int'($urandom_range(0, 3));
      sb  = int'($urandom_range(0, 3));
      imm = int'($urandom_range(0, 255));
      applyStimulus($sformatf("rnd%0d_op%0d", k, op), op, dst, sa, sb, imm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter NREG, default 4, giving the number of 8-bit registers; the select fields are 2 bits wide, and only 4 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: an operation request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port req_op, input, 2 bits: 00 ADD, 01 SUB, 10 LDI, 11 CMP.
REQ-007 The block SHALL have ports req_dst, req_srca and req_srcb, each an input, 2 bits: destination and source register indices.
REQ-008 The block SHALL have port req_imm, input, [0:7]: the LDI immediate.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port done_data, output, [0:7]: the result, valid while done is high.
REQ-011 The block SHALL have ports flag_c, flag_z, flag_n and flag_v, each an output, 1 bit: registered status flags.
REQ-012 The block SHALL have port rd_sel, input, 2 bits, and port rd_data, output, [0:7]: a combinational observation read of the register file.
REQ-013 All [0:7] buses SHALL treat bit 0 as the LSB and bit 7 as the MSB.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and WB.
REQ-015 req_ready SHALL be 1 only in IDLE with reset low.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-017 On acceptance, the block SHALL latch the op, the dst, reg[srca] into operand A, and either reg[srcb] or, for LDI, req_imm into operand B; the state SHALL then go to EXEC.
REQ-018 In EXEC, the latched operands SHALL drive the alu, with subtract=1 for SUB and CMP; r and carry SHALL be registered and the state SHALL go to WB.
REQ-019 For LDI, the result SHALL be operand B unchanged.
REQ-020 In WB, done=1 and done_data=result; reg[dst] SHALL be written at the end of WB except for CMP; the flags SHALL update; the state SHALL then go to IDLE.
REQ-021 Latency: done SHALL be high in the second cycle after the accept edge, and the next accept SHALL be possible on the third edge, giving one operation per 3 cycles.
REQ-022 flag_c SHALL equal the alu carry-out; for SUB and CMP, 1 means no borrow (A>=B unsigned).
REQ-023 flag_z SHALL be 1 when the result is 0x00, and flag_n SHALL equal result bit 7.
REQ-024 flag_v for ADD SHALL be 1 when A[7]==B[7] and r[7]!=A[7].
REQ-025 flag_v for SUB and CMP SHALL be 1 when A[7]!=B[7] and r[7]!=A[7].
REQ-026 LDI SHALL update flag_z and flag_n only, leaving flag_c and flag_v unchanged.
REQ-027 Operands SHALL be sampled at accept, so srca, srcb and dst may be equal with no hazard.
REQ-028 req_valid held while req_ready=0 SHALL be ignored, and request inputs SHALL be don't-care outside accept edges.
REQ-029 ADD and SUB SHALL wrap modulo 256; wrap-around SHALL be reported only by the flags.

Reset
REQ-030 When reset is high at an edge, the state SHALL go to IDLE, all registers to 0x00, all flags to 0, done to 0 and done_data to 0x00.
REQ-031 req_ready SHALL be 0 while reset is high.
REQ-032 A reset asserted in EXEC or WB SHALL abort the operation with no register write and no done pulse, and reset SHALL take priority over a same-edge write.

Structure
REQ-033 A shared package SHALL hold the op encodings (ADD, SUB, LDI, CMP), the state encodings and the width constant 8.
REQ-034 The block SHALL instantiate exactly one existing alu sub-module for the arithmetic; the flags, FSM and register file are local.

Verification
REQ-035 The bench SHALL, after reset, check that rd_data=0x00 for every rd_sel, and that req_ready=1 on the first cycle after reset falls.
REQ-036 The bench SHALL issue LDI r1,0x7F and LDI r2,0x01 then ADD r3=r1+r2, and check r3=0x80 with C=0, Z=0, N=1, V=1, and done exactly 2 cycles after each accept.
REQ-037 The bench SHALL issue LDI r0,0x05, LDI r1,0x07 then SUB r2=r0-r1, and check r2=0xFE with C=0, N=1, V=0.
REQ-038 The bench SHALL issue CMP r1,r1 with r1=0x07, and check Z=1 and C=1 with the register file unchanged.
REQ-039 The bench SHALL issue ADD with 0xFF+0x01, and check result 0x00 with C=1, Z=1 and V=0.
REQ-040 The bench SHALL assert reset during WB of LDI r3,0xAA, and check that no done pulse occurs, r3=0x00 and req_ready returns to 1 after reset falls.
